// File: rtl/led_rx.sv
// rtl/led_rx.sv - serial LED-chain receiver that writes channel words into a framebuffer
// Synchronizes the shift/latch inputs and assembles MSB-first words addressed from 0 after each latch.
module led_rx #(
  parameter  int c_ledboards = 30,
  parameter  int c_bpc       = 12,
  localparam int c_channels  = c_ledboards * 32,
  localparam int AW          = $clog2(c_channels)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk,
  input  logic             i_sdai,
  input  logic             i_slat,
  output logic             o_wen,
  output logic [AW-1:0]    o_waddr,
  output logic [c_bpc-1:0] o_wdata,
  output logic             o_frame,
  output logic             o_err
);

  localparam int WCW = $clog2(c_channels + 1);
  localparam int BCW = (c_bpc > 1) ? $clog2(c_bpc) : 1;
  localparam logic [WCW-1:0] WC_FULL  = WCW'(c_channels);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(c_bpc - 1);

  typedef enum logic [1:0] {ALIGN, RECV, OVERFLOW} state_t;

  logic [2:0]       sclk_q;
  logic [2:0]       slat_q;
  logic [2:0]       sdai_q;
  state_t           state_q;
  logic [WCW-1:0]   wcnt_q;
  logic [BCW-1:0]   bcnt_q;
  logic [c_bpc-1:0] shift_q;
  logic [c_bpc-1:0] shift_d;
  logic             wen_q;
  logic             frame_q;
  logic             err_q;
  logic [AW-1:0]    waddr_q;
  logic [c_bpc-1:0] wdata_q;
  logic             sclk_rise;
  logic             lat_rise;

  // Data rides the same 3-deep pipe; its middle stage lines up with the sclk edge detector.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q <= '0;
      slat_q <= '0;
      sdai_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sclk};
      slat_q <= {slat_q[1:0], i_slat};
      sdai_q <= {sdai_q[1:0], i_sdai};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lat_rise  = slat_q[1] & ~slat_q[2];
  assign shift_d   = {shift_q[c_bpc-2:0], sdai_q[1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ALIGN;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      wen_q   <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (lat_rise) begin
        if (state_q == RECV && wcnt_q == WC_FULL && bcnt_q == '0) begin
          frame_q <= 1'b1;
        end else if (state_q != ALIGN) begin
          err_q <= 1'b1;
        end
        state_q <= RECV;
        wcnt_q  <= '0;
        bcnt_q  <= '0;
        shift_q <= '0;
      end else if (sclk_rise && state_q == RECV) begin
        // A bit arriving after the last channel word marks the frame as overlong.
        if (wcnt_q == WC_FULL) begin
          state_q <= OVERFLOW;
        end else begin
          shift_q <= shift_d;
          if (bcnt_q == LAST_BIT) begin
            wen_q   <= 1'b1;
            waddr_q <= wcnt_q[AW-1:0];
            wdata_q <= shift_d;
            bcnt_q  <= '0;
            wcnt_q  <= wcnt_q + WCW'(1);
          end else begin
            bcnt_q <= bcnt_q + BCW'(1);
          end
        end
      end
    end
  end

  assign o_wen   = wen_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_frame = frame_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_led_rx.sv
// tb/tb_led_rx.sv - scoreboard bench for led_rx with a bit-count reference model
module tb_led_rx;
  localparam int LB   = 1;
  localparam int BPC  = 12;
  localparam int CH   = LB * 32;
  localparam int AW   = $clog2(CH);
  localparam int MASK = (1 << BPC) - 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           sclk  = 1'b0;
  logic           sdai  = 1'b0;
  logic           slat  = 1'b0;
  logic           wen;
  logic           frame;
  logic           err;
  logic [AW-1:0]  waddr;
  logic [BPC-1:0] wdata;

  always #5 clk = ~clk;

  led_rx #(.c_ledboards(LB), .c_bpc(BPC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_sdai(sdai), .i_slat(slat),
    .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_frame(frame), .o_err(err)
  );

  typedef struct {int kind; int addr; int data;} ev_t;  // kind: 0 write, 1 frame, 2 err
  ev_t exp_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit aligned  = 1'b0;
  int nbits    = 0;
  int cur      = 0;

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: every BPC-th bit after a latch completes a word, but only the first CH words are written.
  task automatic send_bit(input bit b);
    sdai = b;
    wait_clk(4);
    sclk = 1'b1;
    if (aligned) begin
      cur = ((cur << 1) | int'(b)) & MASK;
      if (nbits < CH * BPC && (nbits % BPC) == BPC - 1)
        exp_q.push_back('{0, (nbits + 1) / BPC - 1, cur});
      nbits++;
    end
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic send_word(input int w);
    for (int i = BPC - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic latch();
    wait_clk(2);
    slat = 1'b1;
    if (aligned) exp_q.push_back('{(nbits == CH * BPC) ? 1 : 2, 0, 0});
    aligned = 1'b1;
    nbits   = 0;
    cur     = 0;
    wait_clk(4);
    slat = 1'b0;
    wait_clk(4);
  endtask

  task automatic do_reset(input string tag);
    wait_clk(6);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_wen"}, int'(wen), 0);
    check({tag, "_waddr"}, int'(waddr), 0);
    check({tag, "_wdata"}, int'(wdata), 0);
    check({tag, "_pulses"}, int'(frame) + int'(err), 0);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    aligned = 1'b0;
    nbits   = 0;
    cur     = 0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  always @(negedge clk) begin
    if (wen || frame || err) begin
      int  kind;
      ev_t e;
      kind = wen ? 0 : (frame ? 1 : 2);
      check("one_hot", int'(wen) + int'(frame) + int'(err), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind_plus1", kind + 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("kind", kind, e.kind);
        if (e.kind == 0 && kind == 0) begin
          check("waddr", int'(waddr), e.addr);
          check("wdata", int'(wdata), e.data);
        end
      end
    end
  end

  initial begin
    int n;
    int extra;
    wait_clk(3);
    #2;
    check("rst_wen", int'(wen), 0);
    check("rst_outs", int'(frame) + int'(err) + int'(waddr) + int'(wdata), 0);
    rst_n = 1'b1;
    wait_clk(2);

    latch();
    for (int k = 0; k < 32; k++) send_word(32'hA00 + k);
    latch();

    do_reset("r1");
    for (int i = 0; i < 36; i++) send_bit(1'($urandom));
    latch();

    for (int k = 0; k < 31; k++) send_word(int'($urandom) & MASK);
    latch();
    for (int k = 0; k < 33; k++) send_word(int'($urandom) & MASK);
    latch();
    for (int k = 0; k < 32; k++) send_word(int'($urandom) & MASK);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    latch();
    for (int k = 0; k < 32; k++) send_word(int'($urandom) & MASK);
    latch();

    for (int f = 0; f < 3; f++) begin
      n     = int'($urandom_range(30, 34));
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 0;
      for (int k = 0; k < n; k++) send_word(int'($urandom) & MASK);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom));
      latch();
    end

    for (int k = 0; k < 3; k++) send_word(32'h5A0 + k);
    for (int i = 0; i < 6; i++) send_bit(1'($urandom));
    do_reset("r2");
    for (int k = 0; k < 2; k++) send_word(int'($urandom) & MASK);
    latch();
    send_word(int'($urandom) & MASK);
    send_word(int'($urandom) & MASK);
    latch();

    wait_clk(20);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/led_rx.md
LED_RX -- requirements
Module: led_rx

Interface
REQ-001: The block SHALL have parameter c_ledboards, default 30, meaning the number of LED boards in the chain; the channel count is c_channels = c_ledboards*32.
REQ-002: The block SHALL have parameter c_bpc, default 12, meaning bits per channel word.
REQ-003: The block SHALL have port i_clk, input, width 1: the single system clock; all logic is on its rising edge.
REQ-004: The block SHALL have port i_rst_n, input, width 1: asynchronous, active-low reset.
REQ-005: The block SHALL have port i_sclk, input, width 1: serial shift clock, asynchronous to i_clk.
REQ-006: The block SHALL have port i_sdai, input, width 1: serial data, MSB of each word first, valid at the i_sclk rising edge.
REQ-007: The block SHALL have port i_slat, input, width 1: latch; a rising edge marks a frame boundary.
REQ-008: The block SHALL have port o_wen, output, width 1: one-cycle write strobe for the framebuffer write port.
REQ-009: The block SHALL have port o_waddr, output, width $clog2(c_channels): channel address of the strobed word.
REQ-010: The block SHALL have port o_wdata, output, width c_bpc: received channel word.
REQ-011: The block SHALL have port o_frame, output, width 1: one-cycle pulse on a latch closing a well-formed frame.
REQ-012: The block SHALL have port o_err, output, width 1: one-cycle pulse on a latch closing a malformed frame.

Function
REQ-013: i_sclk, i_sdai and i_slat SHALL each pass through a 2-flop synchronizer, then a third flop for edge detection; all three paths SHALL have equal delay.
REQ-014: If i_clk edge N is the first to sample i_sclk (or i_slat) high, the resulting register update SHALL occur at edge N+2; o_wen, o_frame and o_err SHALL be high for exactly the following cycle.
REQ-015: Input constraint: i_sclk high and low phases SHALL each last at least 3 i_clk cycles; i_sdai SHALL be stable for 3 i_clk cycles around each i_sclk rising edge.
REQ-016: The FSM SHALL have states ALIGN (reset state; discard bits until the first latch edge), RECV and OVERFLOW.
REQ-017: ALIGN SHALL transition to RECV on a latch edge, with no o_frame or o_err pulse.
REQ-018: In RECV, each sclk rising edge SHALL shift the synchronized data into the c_bpc-bit shift register (LSB in) and increment the bit counter.
REQ-019: On the c_bpc-th bit, the block SHALL pulse o_wen with o_wdata = the completed word and o_waddr = the word counter; it SHALL then clear the bit counter and increment the word counter.
REQ-020: Words SHALL be addressed in arrival order, starting at 0 after each latch.
REQ-021: When the word counter reaches c_channels, RECV SHALL transition to OVERFLOW; in OVERFLOW, sclk edges SHALL be ignored and no o_wen is produced.
REQ-022: A latch edge in RECV with word counter = c_channels and bit counter = 0 SHALL pulse o_frame; any other latch edge in RECV or in OVERFLOW SHALL pulse o_err.
REQ-023: Any latch edge SHALL clear the word counter, bit counter and shift register, and enter RECV; partial words SHALL be discarded.
REQ-024: If a latch edge and an sclk edge are detected in the same cycle, the latch SHALL take priority and the bit SHALL be discarded.
REQ-025: o_wen, o_frame and o_err SHALL be mutually exclusive in any cycle.
REQ-026: o_waddr and o_wdata SHALL hold their values between strobes.

Reset
REQ-027: Asserting i_rst_n low SHALL immediately force all outputs to 0, clear all counters, the shift register and the synchronizers, and set the state to ALIGN.
REQ-028: A reset asserted mid-word or mid-frame SHALL discard the word or frame, and SHALL produce no strobe after release until a new latch edge and a complete word have been received.

Verification (c_ledboards=1, c_bpc=12, 32 channels)
REQ-029: Reset, latch, 32 words with value 0xA00+k, latch -> 32 o_wen with o_waddr k and o_wdata 0xA00+k for k=0..31, then one o_frame pulse and o_err=0.
REQ-030: After reset, 36 bits with no latch -> no o_wen, o_frame or o_err; the following latch produces no pulse.
REQ-031: Latch, 31 words, latch -> 31 o_wen (addresses 0..30), then one o_err pulse and no o_frame.
REQ-032: Latch, 33 words, latch -> 32 o_wen only (addresses 0..31), then one o_err pulse.
REQ-033: Latch, 32 words plus 5 bits, latch -> 32 o_wen, then one o_err pulse; the next frame starts at address 0 with the correct data.
REQ-034: i_rst_n low after 6 bits of word 3 -> outputs 0 immediately; after release, words without a latch produce no o_wen; after a latch, the first word is written to address 0.
